// File: rtl/dest_data_seq.sv
// Data-path sequencer: steers len+1 beats from the source chosen by each mux entry onto one output stream.
// Optional source-tlast consistency check is built when DEST_TLAST_CHK_EN is defined.
module dest_data_seq #(
  parameter int unsigned DATA_BITS    = 512,
  parameter int unsigned N_DESTS      = 1,
  parameter int unsigned PID_BITS     = 6,
  parameter int unsigned BLEN_BITS    = 4,
  localparam int unsigned N_DESTS_BITS = (N_DESTS > 1) ? $clog2(N_DESTS) : 1,
  localparam int unsigned KEEP_BITS    = DATA_BITS / 8
) (
  input  logic                           aclk,
  input  logic                           aresetn,
  // sequence entries from the arbiter queue
  input  logic                           mux_valid,
  output logic                           mux_ready,
  input  logic [PID_BITS-1:0]            mux_pid,
  input  logic [BLEN_BITS-1:0]           mux_len,
  input  logic [N_DESTS_BITS-1:0]        mux_dest,
  // per-destination source streams, flattened with source i at slice i
  input  logic [N_DESTS-1:0]             s_axis_tvalid,
  output logic [N_DESTS-1:0]             s_axis_tready,
  input  logic [N_DESTS*DATA_BITS-1:0]   s_axis_tdata,
  input  logic [N_DESTS*KEEP_BITS-1:0]   s_axis_tkeep,
  input  logic [N_DESTS-1:0]             s_axis_tlast,
  // shared output stream
  output logic                           m_axis_tvalid,
  input  logic                           m_axis_tready,
  output logic [DATA_BITS-1:0]           m_axis_tdata,
  output logic [KEEP_BITS-1:0]           m_axis_tkeep,
  output logic                           m_axis_tlast,
  output logic [PID_BITS-1:0]            m_pid,
  output logic                           err_dest,
  output logic                           err_tlast
);

  typedef enum logic {IDLE, XFER} state_e;

  state_e                  state_q, state_d;
  logic [BLEN_BITS-1:0]    cnt_q, cnt_d;
  logic [N_DESTS_BITS-1:0] dest_q, dest_d;
  logic [PID_BITS-1:0]     pid_q, pid_d;
  logic                    err_dest_q, err_dest_d;

  logic                    src_tvalid_c;
  logic [DATA_BITS-1:0]    src_tdata_c;
  logic [KEEP_BITS-1:0]    src_tkeep_c;
  logic                    dest_ok_c;
  logic [N_DESTS_BITS-1:0] dest_sel_c;
  logic                    xfer_c;
  logic                    last_c;
  logic                    beat_c;

  // A single-source build ignores dest entirely.
  assign dest_ok_c  = (N_DESTS == 1) || (32'(mux_dest) < N_DESTS);
  assign dest_sel_c = (N_DESTS == 1) ? '0 : mux_dest;

  assign xfer_c = (state_q == XFER);
  assign last_c = (cnt_q == '0);
  assign beat_c = xfer_c && src_tvalid_c && m_axis_tready;

  // Source select by the latched dest
  always_comb begin
    src_tvalid_c = 1'b0;
    src_tdata_c  = '0;
    src_tkeep_c  = '0;
    for (int unsigned i = 0; i < N_DESTS; i++) begin
      if (dest_q == N_DESTS_BITS'(i)) begin
        src_tvalid_c = s_axis_tvalid[i];
        src_tdata_c  = s_axis_tdata[i*DATA_BITS +: DATA_BITS];
        src_tkeep_c  = s_axis_tkeep[i*KEEP_BITS +: KEEP_BITS];
      end
    end
  end

  // Only the selected source is ever acknowledged; the rest hold their data.
  always_comb begin
    s_axis_tready = '0;
    for (int unsigned i = 0; i < N_DESTS; i++) begin
      if (aresetn && xfer_c && (dest_q == N_DESTS_BITS'(i))) begin
        s_axis_tready[i] = m_axis_tready;
      end
    end
  end

  assign m_axis_tvalid = aresetn && xfer_c && src_tvalid_c;
  assign m_axis_tdata  = src_tdata_c;
  assign m_axis_tkeep  = src_tkeep_c;
  assign m_axis_tlast  = xfer_c && last_c;
  assign m_pid         = pid_q;
  assign err_dest      = aresetn && err_dest_q;

  // Next-state: the last-beat cycle also accepts the next entry for zero-bubble chaining
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    dest_d     = dest_q;
    pid_d      = pid_q;
    err_dest_d = 1'b0;
    mux_ready  = 1'b0;
    case (state_q)
      IDLE: begin
        mux_ready = 1'b1;
        if (mux_valid) begin
          if (dest_ok_c) begin
            dest_d  = dest_sel_c;
            pid_d   = mux_pid;
            cnt_d   = mux_len;
            state_d = XFER;
          end else begin
            err_dest_d = 1'b1;
          end
        end
      end
      XFER: begin
        if (beat_c) begin
          if (!last_c) begin
            cnt_d = cnt_q - BLEN_BITS'(1);
          end else begin
            mux_ready = 1'b1;
            state_d   = IDLE;
            if (mux_valid) begin
              if (dest_ok_c) begin
                dest_d  = dest_sel_c;
                pid_d   = mux_pid;
                cnt_d   = mux_len;
                state_d = XFER;
              end else begin
                err_dest_d = 1'b1;
              end
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (!aresetn) begin
      mux_ready = 1'b0;
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      dest_q     <= '0;
      pid_q      <= '0;
      err_dest_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dest_q     <= dest_d;
      pid_q      <= pid_d;
      err_dest_q <= err_dest_d;
    end
  end

`ifdef DEST_TLAST_CHK_EN
  logic src_tlast_c;
  logic err_tlast_q, err_tlast_d;

  always_comb begin
    src_tlast_c = 1'b0;
    for (int unsigned i = 0; i < N_DESTS; i++) begin
      if (dest_q == N_DESTS_BITS'(i)) begin
        src_tlast_c = s_axis_tlast[i];
      end
    end
  end

  // Sticky flag: source tlast disagreed with the count-derived last beat
  always_comb begin
    err_tlast_d = err_tlast_q;
    if (beat_c && (src_tlast_c != last_c)) begin
      err_tlast_d = 1'b1;
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      err_tlast_q <= 1'b0;
    end else begin
      err_tlast_q <= err_tlast_d;
    end
  end

  assign err_tlast = err_tlast_q;
`else
  logic unused_tlast;
  assign unused_tlast = ^s_axis_tlast;
  assign err_tlast    = 1'b0;
`endif

endmodule
